// File: rtl/mii_mac_tx_multi.sv
// Multi-channel MII/RMII Ethernet transmitter: round-robin arbitration of byte-wide AXI-Stream
// sources, with preamble/SFD, zero padding, CRC-32 FCS and IFG for framed channels.
module mii_mac_tx_multi #(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned USE_RMII        = 1,
    parameter logic [7:0]  BYPASS_MASK     = 8'b10,
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned IFG_BYTES       = 12,
    localparam int unsigned DW             = (USE_RMII != 0) ? 2 : 4,
    localparam int unsigned CW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [8*NUM_CH-1:0] saxis_tdata,
    input  logic [NUM_CH-1:0]   saxis_tvalid,
    output logic [NUM_CH-1:0]   saxis_tready,
    input  logic [NUM_CH-1:0]   saxis_tlast,
    output logic [DW-1:0]       mii_d,
    output logic                mii_en,
    output logic                mii_er,
    output logic [CW-1:0]       active_ch,
    output logic                busy,
    output logic                underrun
);

    localparam int unsigned BT       = (USE_RMII != 0) ? 4 : 2;
    localparam int unsigned IFG_CLKS = IFG_BYTES * BT;

    typedef enum logic [3:0] {
        StIdle, StPreamble, StSfd, StData, StPad, StFcs, StUnder, StIfg, StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] grant_q, grant_d, rr_q, rr_d, pick, sel_ch;
    logic [1:0]  sym_q, sym_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d, fcs_q, fcs_d;
    logic [15:0] ifg_q, ifg_d;
    logic        ready, take, to_pad, to_fcs, last_sym;
    logic        ch_valid, ch_last, ch_bypass;
    logic [7:0]  ch_data;
    logic [2:0]  bit_ofs;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // First valid channel at or after the round-robin pointer.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && saxis_tvalid[CW'(idx)]) begin
                found = 1'b1;
                pick  = CW'(idx);
            end
        end
    end

    assign sel_ch    = (state_q == StIdle) ? pick : grant_q;
    assign ch_valid  = saxis_tvalid[sel_ch];
    assign ch_last   = saxis_tlast[sel_ch];
    assign ch_data   = saxis_tdata[{sel_ch, 3'b000} +: 8];
    assign ch_bypass = BYPASS_MASK[sel_ch];
    assign last_sym  = (sym_q == 2'(BT - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        sym_d   = last_sym ? 2'd0 : sym_q + 2'd1;
        idx_d   = idx_q;
        byte_d  = byte_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        fcs_d   = fcs_q;
        ifg_d   = ifg_q;
        ready   = 1'b0;
        take    = 1'b0;
        to_pad  = 1'b0;
        to_fcs  = 1'b0;

        case (state_q)
            StIdle: begin
                sym_d = '0;
                if (|saxis_tvalid) begin
                    grant_d = pick;
                    rr_d    = (pick == CW'(NUM_CH - 1)) ? '0 : pick + CW'(1);
                    idx_d   = '0;
                    if (ch_bypass) begin
                        ready = 1'b1;
                        take  = 1'b1;
                    end else begin
                        state_d = StPreamble;
                        byte_d  = 8'h55;
                    end
                end
            end
            StPreamble: begin
                if (last_sym) begin
                    if (idx_q == 3'd6) begin
                        state_d = StSfd;
                        byte_d  = 8'hD5;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StSfd: begin
                if (last_sym) begin
                    ready = 1'b1;
                    if (ch_valid) take = 1'b1;
                    else state_d = StUnder;
                end
            end
            StData: begin
                if (last_sym) begin
                    if (last_q) begin
                        if (BYPASS_MASK[grant_q]) begin
                            state_d = StIfg;
                            ifg_d   = '0;
                        end else if (cnt_q < 11'(MIN_FRAME_BYTES)) begin
                            to_pad = 1'b1;
                        end else begin
                            to_fcs = 1'b1;
                        end
                    end else begin
                        ready = 1'b1;
                        if (ch_valid) take = 1'b1;
                        else state_d = StUnder;
                    end
                end
            end
            StPad: begin
                if (last_sym) begin
                    if (cnt_q < 11'(MIN_FRAME_BYTES)) to_pad = 1'b1;
                    else to_fcs = 1'b1;
                end
            end
            StFcs: begin
                if (last_sym) begin
                    if (idx_q == 3'd3) begin
                        state_d = StIfg;
                        ifg_d   = '0;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        fcs_d  = fcs_q >> 8;
                        byte_d = fcs_q[15:8];
                    end
                end
            end
            StUnder: begin
                if (last_sym) state_d = StDrain;
            end
            StDrain: begin
                sym_d = '0;
                ready = 1'b1;
                if (ch_valid && ch_last) begin
                    state_d = StIfg;
                    ifg_d   = '0;
                end
            end
            StIfg: begin
                sym_d = '0;
                if (ifg_q == 16'(IFG_CLKS - 1)) begin
                    state_d = StIdle;
                    crc_d   = 32'hFFFF_FFFF;
                    cnt_d   = '0;
                end else begin
                    ifg_d = ifg_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            state_d = StData;
            byte_d  = ch_data;
            last_d  = ch_last;
            crc_d   = crc_byte(crc_q, ch_data);
            cnt_d   = (cnt_q == 11'd2047) ? cnt_q : cnt_q + 11'd1;
        end
        if (to_pad) begin
            state_d = StPad;
            byte_d  = 8'h00;
            crc_d   = crc_byte(crc_q, 8'h00);
            cnt_d   = cnt_q + 11'd1;
        end
        if (to_fcs) begin
            state_d = StFcs;
            idx_d   = '0;
            fcs_d   = ~crc_q;
            byte_d  = ~crc_q[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
            sym_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            crc_q   <= 32'hFFFF_FFFF;
            fcs_q   <= '0;
            ifg_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            sym_q   <= sym_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            fcs_q   <= fcs_d;
            ifg_q   <= ifg_d;
        end
    end

    assign bit_ofs = 3'(sym_q * DW);

    // Outputs decode from registered state so reset clears them without waiting for a clock.
    always_comb begin
        saxis_tready = '0;
        if (ready && !reset) saxis_tready[sel_ch] = 1'b1;
        mii_en   = (state_q == StPreamble) || (state_q == StSfd) || (state_q == StData) ||
                   (state_q == StPad) || (state_q == StFcs) || (state_q == StUnder);
        mii_er   = (state_q == StUnder);
        mii_d    = (mii_en && !mii_er) ? byte_q[bit_ofs +: DW] : '0;
        busy     = (state_q != StIdle);
        underrun = (state_q == StUnder) && (sym_q == 2'd0);
    end

    assign active_ch = grant_q;

endmodule

// File: tb/tb_mii_mac_tx_multi.sv
// Directed bench for mii_mac_tx_multi: an RMII two-channel instance and an MII instance,
// with wire bytes reassembled from the pins and compared against hand-built frames.
module tb_mii_mac_tx_multi;

    typedef logic [7:0] q8_t [$];

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [15:0] a_tdata, b_tdata;
    logic [1:0]  a_tvalid, a_tready, a_tlast, b_tvalid, b_tready, b_tlast;
    logic [1:0]  a_d;
    logic [3:0]  b_d;
    logic        a_en, a_er, a_busy, a_under, a_ch;
    logic        b_en, b_er, b_busy, b_under, b_ch;

    mii_mac_tx_multi #(.NUM_CH(2), .USE_RMII(1), .BYPASS_MASK(8'b10), .MIN_FRAME_BYTES(60),
                       .IFG_BYTES(12)) dut_a (
        .clock(clock), .reset(reset), .saxis_tdata(a_tdata), .saxis_tvalid(a_tvalid),
        .saxis_tready(a_tready), .saxis_tlast(a_tlast), .mii_d(a_d), .mii_en(a_en),
        .mii_er(a_er), .active_ch(a_ch), .busy(a_busy), .underrun(a_under));

    mii_mac_tx_multi #(.NUM_CH(2), .USE_RMII(0), .BYPASS_MASK(8'b10), .MIN_FRAME_BYTES(60),
                       .IFG_BYTES(12)) dut_b (
        .clock(clock), .reset(reset), .saxis_tdata(b_tdata), .saxis_tvalid(b_tvalid),
        .saxis_tready(b_tready), .saxis_tlast(b_tlast), .mii_d(b_d), .mii_en(b_en),
        .mii_er(b_er), .active_ch(b_ch), .busy(b_busy), .underrun(b_under));

    int total = 0;
    int bad   = 0;
    bit abort = 1'b0;

    logic [3:0] mon_d [2];
    logic       mon_en [2], mon_er [2], mon_busy [2], mon_under [2], mon_ch [2];
    logic [1:0] mon_rdy [2];
    assign mon_d[0] = {2'b00, a_d};
    assign mon_d[1] = b_d;
    assign mon_en[0] = a_en;       assign mon_en[1] = b_en;
    assign mon_er[0] = a_er;       assign mon_er[1] = b_er;
    assign mon_busy[0] = a_busy;   assign mon_busy[1] = b_busy;
    assign mon_under[0] = a_under; assign mon_under[1] = b_under;
    assign mon_ch[0] = a_ch;       assign mon_ch[1] = b_ch;
    assign mon_rdy[0] = a_tready;  assign mon_rdy[1] = b_tready;

    logic [7:0] wire_q [2][$];
    int         grant_log [$];
    int         en_clks [2], er_clks [2], ifg_clks [2], und_cnt [2], viol [2], scnt [2];
    logic [7:0] acc [2];
    logic       prev_busy [2] = '{1'b0, 1'b0};

    // Pin monitor: rebuilds bytes LSB-first and tallies enable/error/idle clocks.
    always @(negedge clock) begin
        for (int m = 0; m < 2; m++) begin
            int bt, dw;
            bt = (m == 0) ? 4 : 2;
            dw = (m == 0) ? 2 : 4;
            if (mon_en[m]) en_clks[m]++;
            if (mon_er[m]) er_clks[m]++;
            if (mon_busy[m] && !mon_en[m]) ifg_clks[m]++;
            if (mon_under[m]) und_cnt[m]++;
            if (m == 0 && mon_busy[m] && !prev_busy[m]) grant_log.push_back(int'(mon_ch[m]));
            prev_busy[m] = mon_busy[m];
            if ($countones(mon_rdy[m]) > 1) viol[m]++;
            if (mon_busy[m] && ((mon_rdy[m] & ~(2'b01 << mon_ch[m])) != 2'b00)) viol[m]++;
            if (mon_en[m] && !mon_er[m]) begin
                acc[m] = acc[m] | (8'(mon_d[m]) << (scnt[m] * dw));
                scnt[m]++;
                if (scnt[m] == bt) begin
                    wire_q[m].push_back(acc[m]);
                    scnt[m] = 0;
                    acc[m]  = 8'h00;
                end
            end else if (!mon_en[m]) begin
                scnt[m] = 0;
                acc[m]  = 8'h00;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic q8_t ramp(input int n, input logic [7:0] base);
        q8_t q;
        for (int k = 0; k < n; k++) q.push_back(8'(base + k));
        return q;
    endfunction

    function automatic logic [31:0] crc32(input q8_t b);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic q8_t framed(input q8_t pkt);
        q8_t body, f;
        logic [31:0] fcs;
        body = pkt;
        while (body.size() < 60) body.push_back(8'h00);
        fcs = crc32(body);
        for (int k = 0; k < 7; k++) f.push_back(8'h55);
        f.push_back(8'hD5);
        foreach (body[i]) f.push_back(body[i]);
        for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
        return f;
    endfunction

    task automatic drive(input int sel, input int ch, input logic v, input logic [7:0] d,
                         input logic l);
        if (sel == 0) begin
            a_tvalid[ch] = v; a_tdata[8*ch +: 8] = d; a_tlast[ch] = l;
        end else begin
            b_tvalid[ch] = v; b_tdata[8*ch +: 8] = d; b_tlast[ch] = l;
        end
    endtask

    function automatic logic rdy(input int sel, input int ch);
        return (sel == 0) ? a_tready[ch] : b_tready[ch];
    endfunction

    // Entered at a falling edge; holds each byte until ready is seen, optional valid gap.
    task automatic send(input int sel, input int ch, input q8_t pkt, input int gap_at,
                        input int gap_len);
        int t;
        for (int k = 0; k < pkt.size(); k++) begin
            if (abort) break;
            if (k == gap_at) begin
                drive(sel, ch, 1'b0, 8'h00, 1'b0);
                repeat (gap_len) @(negedge clock);
            end
            drive(sel, ch, 1'b1, pkt[k], k == pkt.size() - 1);
            #1;
            t = 0;
            while (!rdy(sel, ch) && !abort && t < 3000) begin
                @(negedge clock);
                #1;
                t++;
            end
            if (abort) break;
            if (t >= 3000) begin
                total++;
                bad++;
                $error("FAIL send_timeout: observed=no tready on ch%0d expected=tready", ch);
                break;
            end
            @(posedge clock);
            @(negedge clock);
        end
        drive(sel, ch, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input int sel);
        int t;
        t = 0;
        while (((sel == 0) ? a_busy : b_busy) && t < 5000) begin
            @(negedge clock);
            t++;
        end
        chk("idle_reached", (sel == 0) ? a_busy : b_busy, 1'b0);
    endtask

    task automatic clr();
        @(posedge clock);
        #1;
        for (int m = 0; m < 2; m++) begin
            wire_q[m].delete();
            en_clks[m] = 0; er_clks[m] = 0; ifg_clks[m] = 0; und_cnt[m] = 0; viol[m] = 0;
        end
        grant_log.delete();
        @(negedge clock);
    endtask

    task automatic cmp_wire(input int m, input string tag, input q8_t exp);
        chk({tag, "_len"}, wire_q[m].size(), exp.size());
        for (int i = 0; i < exp.size() && i < wire_q[m].size(); i++)
            chk($sformatf("%s[%0d]", tag, i), wire_q[m][i], exp[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        q8_t pk, exp;
        reset = 1'b1;
        a_tdata = '0; a_tvalid = '0; a_tlast = '0;
        b_tdata = '0; b_tvalid = '0; b_tlast = '0;
        repeat (3) @(negedge clock);

        chk("rst_en", a_en, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_er", a_er, 1'b0);
        chk("rst_ch", a_ch, 1'b0);
        chk("rst_d", a_d, 2'b00);
        chk("rst_b_en", b_en, 1'b0);
        a_tvalid[1] = 1'b1;
        #1;
        chk("rst_rdy_bypass", a_tready, 2'b00);
        a_tvalid[1] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", a_busy, 1'b0);
        chk("idle_under", a_under, 1'b0);

        // 1: framed 64-byte ramp
        clr();
        pk = ramp(64, 8'h00);
        send(0, 0, pk, -1, 0);
        wait_idle(0);
        cmp_wire(0, "t1", framed(pk));
        chk("t1_en_clks", en_clks[0], 304);
        chk("t1_ifg_clks", ifg_clks[0], 48);
        chk("t1_er_clks", er_clks[0], 0);
        chk("t1_ch", a_ch, 1'b0);

        // 2: short frame padded to 60
        clr();
        pk = ramp(10, 8'hA0);
        send(0, 0, pk, -1, 0);
        wait_idle(0);
        exp = framed(pk);
        chk("t2_exp_len", exp.size(), 72);
        cmp_wire(0, "t2", exp);
        chk("t2_en_clks", en_clks[0], 288);
        chk("t2_ifg_clks", ifg_clks[0], 48);

        // 3: bypass channel carries its own preamble, nothing added
        clr();
        pk.delete();
        for (int k = 0; k < 7; k++) pk.push_back(8'h55);
        pk.push_back(8'hD5);
        for (int k = 0; k < 12; k++) pk.push_back(8'(8'h10 + k));
        send(0, 1, pk, -1, 0);
        wait_idle(0);
        cmp_wire(0, "t3", pk);
        chk("t3_en_clks", en_clks[0], 80);
        chk("t3_ifg_clks", ifg_clks[0], 48);
        chk("t3_ch", a_ch, 1'b1);

        // 4: both channels contending from reset
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        clr();
        fork
            begin
                for (int p = 0; p < 3; p++) send(0, 0, ramp(4, 8'(8'h40 + 16 * p)), -1, 0);
            end
            begin
                for (int p = 0; p < 3; p++) send(0, 1, ramp(3, 8'(8'hC0 + 16 * p)), -1, 0);
            end
        join
        wait_idle(0);
        exp.delete();
        for (int p = 0; p < 3; p++)
            exp = {exp, framed(ramp(4, 8'(8'h40 + 16 * p))), ramp(3, 8'(8'hC0 + 16 * p))};
        cmp_wire(0, "t4", exp);
        chk("t4_grants", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("t4_grant[%0d]", i), grant_log[i], i % 2);
        chk("t4_ready_viol", viol[0], 0);

        // 5: underrun after five bytes, then drain to tlast
        clr();
        pk = ramp(12, 8'h20);
        send(0, 0, pk, 5, 20);
        wait_idle(0);
        exp.delete();
        for (int k = 0; k < 7; k++) exp.push_back(8'h55);
        exp.push_back(8'hD5);
        for (int k = 0; k < 5; k++) exp.push_back(pk[k]);
        cmp_wire(0, "t5", exp);
        chk("t5_en_clks", en_clks[0], 56);
        chk("t5_er_clks", er_clks[0], 4);
        chk("t5_underrun", und_cnt[0], 1);

        // 6: reset in the middle of data, then a clean frame
        clr();
        fork
            send(0, 0, ramp(40, 8'h00), -1, 0);
            begin
                repeat (60) @(negedge clock);
                chk("t6_mid_en", a_en, 1'b1);
                #2 reset = 1'b1;
                #1;
                chk("t6_rst_en", a_en, 1'b0);
                chk("t6_rst_rdy", a_tready, 2'b00);
                chk("t6_rst_busy", a_busy, 1'b0);
                abort = 1'b1;
            end
        join
        @(negedge clock);
        reset = 1'b0;
        abort = 1'b0;
        clr();
        pk = ramp(8, 8'h70);
        send(0, 0, pk, -1, 0);
        wait_idle(0);
        cmp_wire(0, "t6", framed(pk));
        chk("t6_en_clks", en_clks[0], 288);

        // 7: MII instance, same 64-byte frame at two clocks per byte
        clr();
        pk = ramp(64, 8'h00);
        send(1, 0, pk, -1, 0);
        wait_idle(1);
        cmp_wire(1, "t7", framed(pk));
        chk("t7_en_clks", en_clks[1], 152);
        chk("t7_ifg_clks", ifg_clks[1], 24);
        chk("t7_ready_viol", viol[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
